// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the HI/LO divide controller.
//   div_state_t : controller state encoding
//   DIV_STEPS   : number of shift-subtract iterations (one per quotient bit)
//   STEP_W      : width of the iteration counter
//   mag()       : two's-complement magnitude helper
package div_pkg;

  localparam int DIV_STEPS = 32;
  localparam int STEP_W    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } div_state_t;

  function automatic logic [31:0] mag(input logic neg, input logic [31:0] v);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// div_core: unsigned restoring shift-subtract divider, one quotient bit per cycle.
// Ports:
//   Clk, Reset_n            clock, async active-low reset
//   load                    load Q/D from the magnitudes, clear R and step
//   step_en                 perform one iteration
//   dividend_mag, divisor_mag  unsigned operands (32 bit)
//   rem, quo                current remainder / quotient registers
//   last_step               high while the final (32nd) iteration is pending
module div_core
  import div_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        load,
  input  logic        step_en,
  input  logic [31:0] dividend_mag,
  input  logic [31:0] divisor_mag,
  output logic [31:0] rem,
  output logic [31:0] quo,
  output logic        last_step
);

  logic [31:0]       r_q;
  logic [31:0]       q_q;
  logic [31:0]       d_q;
  logic [STEP_W-1:0] step_q;

  logic [32:0] r_shift;
  logic [32:0] r_diff;
  logic        qbit;
  logic [31:0] r_next;

  // The remainder stays below D, so the stored value needs only 32 bits; the
  // 33-bit shifted value is compared by subtraction, and bit 32 of the
  // difference is the borrow (set exactly when r_shift < D).
  always_comb begin
    r_shift = {r_q, q_q[31]};
    r_diff  = r_shift - {1'b0, d_q};
    qbit    = ~r_diff[32];
    r_next  = qbit ? r_diff[31:0] : r_shift[31:0];
  end

  assign last_step = (step_q == STEP_W'(DIV_STEPS - 1));
  assign rem       = r_q;
  assign quo       = q_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      step_q <= '0;
    end else if (load) begin
      r_q    <= '0;
      q_q    <= dividend_mag;
      d_q    <= divisor_mag;
      step_q <= '0;
    end else if (step_en) begin
      r_q    <= r_next;
      q_q    <= {q_q[30:0], qbit};
      step_q <= step_q + STEP_W'(1);
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multicycle DIV/DIVU controller for the HI/LO unit.
// Ports:
//   Clk, Reset_n      clock, async active-low reset
//   start, signed_op  request and DIV(1)/DIVU(0) select, sampled in IDLE
//   dividend, divisor operands, sampled with start
//   abort             flush an in-flight operation
//   busy              high while not IDLE
//   done, div_zero    one-cycle completion pulses
//   hi, lo            remainder / quotient registers
//
// state | meaning
// IDLE  | waiting for start; operands and signs latched on acceptance
// PREP  | divide-by-zero check, load divider core
// RUN   | 32 shift-subtract iterations
// FIX   | apply result signs, write HI/LO, pulse done
module div_ctrl
  import div_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  div_state_t  state;
  logic        sign_q;
  logic        sign_r;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic        core_load;
  logic        core_step;
  logic [31:0] core_rem;
  logic [31:0] core_quo;
  logic        core_last;

  assign busy      = (state != IDLE);
  assign core_load = (state == PREP) && !abort && (b_mag != 32'd0);
  assign core_step = (state == RUN) && !abort;

  div_core u_core (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .load         (core_load),
    .step_en      (core_step),
    .dividend_mag (a_mag),
    .divisor_mag  (b_mag),
    .rem          (core_rem),
    .quo          (core_quo),
    .last_step    (core_last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      a_mag    <= '0;
      b_mag    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              sign_q <= signed_op & (dividend[31] ^ divisor[31]);
              sign_r <= signed_op & dividend[31];
              a_mag  <= mag(signed_op & dividend[31], dividend);
              b_mag  <= mag(signed_op & divisor[31], divisor);
              state  <= PREP;
            end
          end
          PREP: begin
            if (b_mag == 32'd0) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= RUN;
            end
          end
          RUN: begin
            if (core_last) state <= FIX;
          end
          FIX: begin
            lo    <= mag(sign_q, core_quo);
            hi    <= mag(sign_r, core_rem);
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  div_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input logic dz);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.dz = dz;
    sb_q.push_back(e);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n) begin
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no completion", hi, lo);
        end else begin
          e = sb_q.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        end
      end else if (div_zero) begin
        chk("div_zero_without_done", {31'd0, div_zero}, 32'd0);
      end
    end
  end

  // Drives one request; returns at the negedge after the sampling edge (k=0).
  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input bit ab);
    @(negedge Clk);
    start     = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    abort     = ab;
    @(negedge Clk);
    start    = 1'b0;
    abort    = 1'b0;
    dividend = '0;
    divisor  = '0;
  endtask

  // Counts negedges until done; k0 is the current cycle index after E0.
  task automatic wait_done(input string name, input int k0, input int max,
                           output int k, output int bcnt);
    k    = k0;
    bcnt = busy ? 1 : 0;
    while (!done && k < max) begin
      @(negedge Clk);
      k++;
      if (busy) bcnt++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, k);
    end
  endtask

  initial begin
    int k;
    int bc;
    int d0;

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // 100 / 7 unsigned: latency and busy window
    push(32'd2, 32'd14, 1'b0);
    issue(1'b0, 32'd100, 32'd7, 1'b0);
    wait_done("u100_7", 0, 60, k, bc);
    chk("u100_7_latency", k, 32'd34);
    chk("u100_7_busy_cycles", bc, 32'd34);
    chk("u100_7_busy_in_done", {31'd0, busy}, 32'd0);

    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("s_m7_2", 0, 60, k, bc);
    chk("s_m7_2_latency", k, 32'd34);

    push(32'd1, 32'hFFFF_FFFD, 1'b0);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_done("s_7_m2", 0, 60, k, bc);

    push(32'd0, 32'h8000_0000, 1'b0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("s_ovf", 0, 60, k, bc);

    push(32'h8000_0000, 32'd0, 1'b0);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("u_ovf", 0, 60, k, bc);

    // Set hi=0x11, lo=0x22, then divide by zero and restart in the done cycle
    push(32'h11, 32'h22, 1'b0);
    issue(1'b0, 32'h451, 32'h20, 1'b0);
    wait_done("setup", 0, 60, k, bc);
    push(32'h11, 32'h22, 1'b1);
    issue(1'b1, 32'd5, 32'd0, 1'b0);
    wait_done("dz", 0, 10, k, bc);
    chk("dz_latency", k, 32'd1);
    chk("dz_busy_in_done", {31'd0, busy}, 32'd0);
    push(32'd0, 32'd3, 1'b0);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd3;
    @(negedge Clk);
    start = 1'b0;
    chk("restart_busy", {31'd0, busy}, 32'd1);
    wait_done("restart", 0, 60, k, bc);
    chk("restart_latency", k, 32'd34);

    // start while busy is ignored
    push(32'd2, 32'd14, 1'b0);
    issue(1'b0, 32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge Clk);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge Clk);
    start = 1'b0;
    wait_done("busy_start", 11, 60, k, bc);
    chk("busy_start_latency", k, 32'd34);
    @(negedge Clk);
    d0 = done_cnt;
    repeat (45) @(negedge Clk);
    chk("busy_start_single_done", done_cnt - d0, 32'd0);

    // abort mid-run
    issue(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge Clk);
    d0    = done_cnt;
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge Clk);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_hi", hi, 32'd2);
    chk("abort_lo", lo, 32'd14);

    // abort together with start in IDLE
    d0 = done_cnt;
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    chk("abort_start_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge Clk);
    chk("abort_start_no_done", done_cnt - d0, 32'd0);

    // async reset mid-run, then a fresh 9/3
    issue(1'b0, 32'd100, 32'd7, 1'b0);
    repeat (20) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_div_zero", {31'd0, div_zero}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    push(32'd0, 32'd3, 1'b0);
    issue(1'b0, 32'd9, 32'd3, 1'b0);
    wait_done("post_rst", 0, 60, k, bc);
    chk("post_rst_latency", k, 32'd34);
    repeat (5) @(negedge Clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multicycle divide controller for the processor's HI/LO unit. Accepts DIV/DIVU requests from the main control unit and converts signed operands to magnitudes. Sequences an iterative 32-step unsigned divider core, then applies MIPS sign rules separately to quotient and remainder. Writes HI (remainder) and LO (quotient), reports divide-by-zero, and supports abort on exception flush.

## Interface
Parameters:
- none (widths fixed at 32; step count from package)

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- signed_op  in  1  1 = DIV (signed), 0 = DIVU; sampled with start
- dividend  in  32  sampled with start
- divisor  in  32  sampled with start
- abort  in  1  cancel in-flight operation (exception flush)
- busy  out  1  high whenever state ≠ IDLE; control unit stalls on it
- done  out  1  one-cycle pulse, operation finished (incl. div-by-zero)
- div_zero  out  1  one-cycle pulse coincident with done when divisor = 0
- hi  out  32  remainder register
- lo  out  32  quotient register

## Operation
- States: IDLE, PREP, RUN, FIX.
- IDLE: on start & !abort → PREP.
  - Latch sign_q = signed_op & (dividend[31] ^ divisor[31]) and sign_r = signed_op & dividend[31].
  - Latch operand magnitudes: two's-complement negate when signed_op and MSB set.
- PREP:
  - divisor magnitude = 0 → IDLE; pulse done and div_zero; hi/lo unchanged.
  - Otherwise load core: R=0 (33 bit), Q=|dividend|, D=|divisor|, step=0; → RUN.
- RUN, one step per cycle:
  - R' = {R[31:0], Q[31]}.
  - If R' ≥ D: R' -= D, qbit=1; else qbit=0.
  - Q = {Q[30:0], qbit}; step++.
  - After step 31 → FIX.
- FIX:
  - lo ← sign_q ? -Q : Q.
  - hi ← sign_r ? -R[31:0] : R[31:0].
  - Pulse done; → IDLE.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: no special handling; the natural result is lo=0x80000000, hi=0.
- start while busy: ignored, not queued.
- abort in any non-IDLE state: → IDLE next edge; no done; hi/lo unchanged.
- abort with start in IDLE: abort wins, request dropped.
- Reset_n low, any time incl. mid-RUN: state IDLE, hi=lo=0, busy=done=div_zero=0, core registers cleared.

## Timing
- E0 = edge sampling start.
- Normal latency:
  - PREP after E0; RUN from E1; steps on E2..E33; FIX after E33.
  - done high in the cycle after E34, i.e. 34 cycles after E0; hi/lo valid in that same cycle and held until next completion.
  - busy high from E0 through E34; low in the same cycle done is high.
  - New start accepted in the done cycle.
- Divide-by-zero: done/div_zero high after E1; busy low in that cycle.
- abort seen at edge Ek → busy low after Ek.
- done and div_zero are registered, never combinational from inputs.

## Structure
- Package div_pkg:
  - state typedef (IDLE, PREP, RUN, FIX)
  - DIV_STEPS = 32
  - step counter width (6 bits)
- Sub-module div_core:
  - unsigned shift-subtract datapath (R, Q, D, step) with load/step controls and a last_step flag.
  - div_ctrl owns the FSM, sign handling, HI/LO registers and handshake.

## Test plan
- Unsigned 100 / 7 → done exactly 34 cycles after E0; lo=14, hi=2; busy high 34 cycles.
- Signed -7 / 2 (0xFFFFFFF9, 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed 7 / -2 → lo=0xFFFFFFFD, hi=1.
- 0x80000000 / 0xFFFFFFFF:
  - signed → lo=0x80000000, hi=0.
  - unsigned → lo=0, hi=0x80000000.
- Divide by zero, prior hi=0x11, lo=0x22 → done & div_zero after E1; hi/lo unchanged; next start accepted immediately.
- start pulsed again at cycle 10 of a run → ignored, single done at cycle 34. abort at cycle 10 → busy low next cycle, no done, hi/lo unchanged. abort+start together in IDLE → nothing starts.
- Reset_n asserted at cycle 20 of a run → all outputs 0 immediately (async); after release a fresh 9/3 completes with lo=3, hi=0.
